// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
//   clock). It feeds the 7-segment digit decoders. The result register o_bcd
//   only changes on the DONE edge or at reset, so the displays never flicker
//   while a new value is being converted.
//
// Optional build macro:
//   BIN2BCD_LEAD_ZERO_BLANK_EN - leading zero digits above digit 0 are output
//   as 4'hF so the downstream decoder blanks them. The reset value of o_bcd
//   then matches a converted 0, which is all 4'hF except digit 0 = 4'h0.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  conversion request, sampled only while o_busy = 0
//   i_bin    unsigned operand, captured on the accepting edge
//   o_busy   high while a conversion runs (state != IDLE)
//   o_done   one-cycle pulse, o_bcd updated in the same cycle
//   o_bcd    packed BCD result, digit k at [4k+3:4k], digit 0 least significant
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [BCD_W-1:0] BCD_ONES = '1;
`ifdef BIN2BCD_LEAD_ZERO_BLANK_EN
  // Same pattern as a converted zero: blank every digit except digit 0.
  localparam logic [BCD_W-1:0] BCD_RST = BCD_ONES << 4;
`else
  localparam logic [BCD_W-1:0] BCD_RST = BCD_ONES & '0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BIN_W-1:0]   shadow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               done_q;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_d;
  logic [BCD_W-1:0]   bcd_d;

  // Add-3 correction on every scratch digit that is 5 or more, so the
  // following left shift carries into the next decimal digit correctly.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                  ? scratch_q[4*gi +: 4] + 4'd3
                                  : scratch_q[4*gi +: 4];
  end

  // Shift {scratch, shadow} left by one: the shadow MSB enters the scratch LSB.
  assign scratch_d = {scratch_adj[BCD_W-2:0], shadow_q[BIN_W-1]};

  // Formatting of the final result before it is loaded into o_bcd.
  assign bcd_d[3:0] = scratch_q[3:0];
`ifdef BIN2BCD_LEAD_ZERO_BLANK_EN
  // lz[k] = digit k and every digit above it are zero.
  logic [DIGITS:1] lz;
  assign lz[DIGITS] = 1'b1;
  for (genvar gi = DIGITS - 1; gi >= 1; gi--) begin : g_blank
    assign lz[gi] = lz[gi+1] & (scratch_q[4*gi +: 4] == 4'd0);
    assign bcd_d[4*gi +: 4] = lz[gi] ? 4'hF : scratch_q[4*gi +: 4];
  end
`else
  assign bcd_d[BCD_W-1:4] = scratch_q[BCD_W-1:4];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      bcd_q     <= BCD_RST;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            shadow_q  <= i_bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shadow_q  <= shadow_q << 1;
          cnt_q     <= cnt_q - CNT_W'(1);
          // Counter at 1 means this edge performs the last of BIN_W shifts.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= bcd_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;
  assign o_bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Directed bench for bin2bcd_seq. Each accepted conversion pushes its
//   expected result (from a divide/modulo decimal model) into a scoreboard
//   queue; the entry is popped and compared when o_done pulses.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = BIN_W + 1;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int n_vec;
  int n_err;
  logic [4*DIGITS-1:0] sb_q[$];

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_bin  (bin),
    .o_busy (busy),
    .o_done (done),
    .o_bcd  (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference model.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_LEAD_ZERO_BLANK_EN
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (r[4*k +: 4] != 4'd0) break;
      r[4*k +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Start a conversion at the current negedge (inputs are driven away from
  // the rising edge) and wait for o_done. inj_a/inj_b are cycle indices at
  // which a spurious i_start with i_bin=777 is driven while busy.
  task automatic run(input int unsigned val, input int inj_a, input int inj_b);
    int k;
    int busy_cnt;
    logic [4*DIGITS-1:0] exp;
    check("idle_before_start", 32'(busy), 32'd0);
    bin   = BIN_W'(val);
    start = 1'b1;
    sb_q.push_back(ref_bcd(val));
    @(negedge clk);
    k = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      if (k == inj_a || k == inj_b) begin
        start = 1'b1;
        bin   = 16'd777;
      end else begin
        start = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(k), 32'(LAT));
    check("busy_cycles", 32'(busy_cnt), 32'(LAT));
    check("busy_at_done", 32'(busy), 32'd0);
    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check("bcd_result", 32'(bcd), 32'(exp));
      $display("conv bin=%0d bcd=%h exp=%h latency=%0d", val, bcd, exp, k);
    end
  endtask

  // Result must hold and no o_done may appear for n cycles.
  task automatic hold(input int n);
    logic [4*DIGITS-1:0] prev;
    prev = bcd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("hold_done_low", 32'(done), 32'd0);
      check("hold_bcd", 32'(bcd), 32'(prev));
    end
  endtask

  logic [4*DIGITS-1:0] rst_val;
  logic [4*DIGITS-1:0] before_rst;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_val = ref_bcd(0);
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'(rst_val));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 20 cycles with no start.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_bcd", 32'(bcd), 32'(rst_val));
    end
    $display("idle 20 cycles bcd=%h", bcd);

    // Basic conversion followed by hold.
    run(1234, -1, -1);
    hold(5);

    // Back-to-back at minimum spacing: max then zero.
    run(65535, -1, -1);
    run(0, -1, -1);
    hold(2);

    // Requests during SHIFT and during the DONE state are ignored.
    run(4096, 4, 16);
    hold(20);

    // Reset in the middle of a 50000 conversion.
    before_rst = bcd;
    bin   = 16'd50000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("midconv_busy", 32'(busy), 32'd1);
      check("midconv_bcd_held", 32'(bcd), 32'(before_rst));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'(rst_val));
    $display("reset mid-conversion bcd=%h busy=%0d", bcd, busy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("inrst_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    hold(20);
    run(9, -1, -1);

    // Digit boundaries and extremes.
    run(1, -1, -1);
    run(10, -1, -1);
    run(99, -1, -1);
    run(100, -1, -1);
    run(999, -1, -1);
    run(1000, -1, -1);
    run(9999, -1, -1);
    run(10000, -1, -1);
    run(59999, -1, -1);
    run(65534, -1, -1);
    hold(3);

    // Random sample of the operand space.
    for (int i = 0; i < 60; i++) begin
      run($urandom_range(0, 65535), -1, -1);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
